pipe_stage_reg: RTL and testbench

- Parametrised inter-stage pipeline register for the P7 five-stage MIPS core. One instance per D/E, E/M and M/W boundary.
- Carries instr, PC, delay-slot flag, an exception code and NUM_DATA payload words, plus a valid bit.
- Supports hold on stall, bubble insertion on flush, and interrupt redirect to the handler PC.
- First-exception-wins merging of an incoming exception code with one detected locally in this stage.
- Saturating stall and bubble performance counters.

---
 rtl/pipe_stage_reg.sv | 99 +++++++++
 tb/tb_pipe_stage_reg.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register for the five-stage core: hold on stall, bubble on
// flush or invalid input, interrupt redirect, first-exception-wins merge, perf counters.
module pipe_stage_reg #(
    parameter int          DATA_W            = 32,
    parameter int          NUM_DATA          = 3,
    parameter int          EXC_W             = 5,
    parameter logic [31:0] HANDLER_PC        = 32'h0000_4180,
    parameter bit          KEEP_PC_ON_BUBBLE = 1'b1,
    parameter int          CNT_W             = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         int_req,
    input  logic                         flush,
    input  logic                         stall,
    input  logic                         clr_cnt,
    input  logic                         valid_in,
    input  logic [31:0]                  instr_in,
    input  logic [31:0]                  pc_in,
    input  logic                         bd_in,
    input  logic [EXC_W-1:0]             exc_in,
    input  logic [EXC_W-1:0]             exc_local,
    input  logic [NUM_DATA*DATA_W-1:0]   data_in,
    output logic                         valid_out,
    output logic [31:0]                  instr_out,
    output logic [31:0]                  pc_out,
    output logic                         bd_out,
    output logic [EXC_W-1:0]             exc_out,
    output logic [NUM_DATA*DATA_W-1:0]   data_out,
    output logic [CNT_W-1:0]             stall_cnt,
    output logic [CNT_W-1:0]             bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             bubble_ev;
    logic             stall_ev;
    logic [EXC_W-1:0] exc_merged;
    logic [31:0]      bubble_pc;
    logic             bubble_bd;

    // An invalid upstream slot only becomes a bubble when the stage is not held.
    always_comb begin
        bubble_ev  = 1'b0;
        stall_ev   = 1'b0;
        if (!int_req) begin
            bubble_ev = flush | (~stall & ~valid_in);
            stall_ev  = ~flush & stall;
        end
        exc_merged = (exc_in != '0) ? exc_in : exc_local;
        bubble_pc  = KEEP_PC_ON_BUBBLE ? pc_in : 32'h0;
        bubble_bd  = KEEP_PC_ON_BUBBLE ? bd_in : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            instr_out <= '0;
            pc_out    <= '0;
            bd_out    <= 1'b0;
            exc_out   <= '0;
            data_out  <= '0;
        end else if (int_req) begin
            valid_out <= 1'b0;
            instr_out <= '0;
            pc_out    <= HANDLER_PC;
            bd_out    <= 1'b0;
            exc_out   <= '0;
            data_out  <= '0;
        end else if (bubble_ev) begin
            valid_out <= 1'b0;
            instr_out <= '0;
            pc_out    <= bubble_pc;
            bd_out    <= bubble_bd;
            exc_out   <= '0;
            data_out  <= '0;
        end else if (!stall_ev) begin
            valid_out <= 1'b1;
            instr_out <= instr_in;
            pc_out    <= pc_in;
            bd_out    <= bd_in;
            exc_out   <= exc_merged;
            data_out  <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr_cnt) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stall_ev && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + 1'b1;
            if (bubble_ev && bubble_cnt != CNT_MAX)
                bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a default instance plus a narrow-counter,
// zero-PC-on-bubble instance sharing the same stimulus.
module tb_pipe_stage_reg;

    localparam logic [95:0] D1 = 96'h11111111_22222222_33333333;
    localparam logic [95:0] D2 = 96'hAAAA0001_BBBB0002_CCCC0003;
    localparam logic [95:0] D3 = 96'hDEAD0000_BEEF0001_CAFE0002;

    logic        clk = 1'b0;
    logic        reset, int_req, flush, stall, clr_cnt, valid_in, bd_in;
    logic [31:0] instr_in, pc_in;
    logic [4:0]  exc_in, exc_local;
    logic [95:0] data_in;

    logic        valid_out, bd_out, s_valid_out, s_bd_out;
    logic [31:0] instr_out, pc_out, s_instr_out, s_pc_out;
    logic [4:0]  exc_out, s_exc_out;
    logic [95:0] data_out, s_data_out;
    logic [15:0] stall_cnt, bubble_cnt;
    logic [1:0]  s_stall_cnt, s_bubble_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
        logic [95:0] data;
        logic [15:0] sc;
        logic [15:0] bc;
        logic        bub;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .int_req(int_req), .flush(flush), .stall(stall),
        .clr_cnt(clr_cnt), .valid_in(valid_in), .instr_in(instr_in), .pc_in(pc_in),
        .bd_in(bd_in), .exc_in(exc_in), .exc_local(exc_local), .data_in(data_in),
        .valid_out(valid_out), .instr_out(instr_out), .pc_out(pc_out), .bd_out(bd_out),
        .exc_out(exc_out), .data_out(data_out), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_reg #(.CNT_W(2), .KEEP_PC_ON_BUBBLE(1'b0)) dut_s (
        .clk(clk), .reset(reset), .int_req(int_req), .flush(flush), .stall(stall),
        .clr_cnt(clr_cnt), .valid_in(valid_in), .instr_in(instr_in), .pc_in(pc_in),
        .bd_in(bd_in), .exc_in(exc_in), .exc_local(exc_local), .data_in(data_in),
        .valid_out(s_valid_out), .instr_out(s_instr_out), .pc_out(s_pc_out), .bd_out(s_bd_out),
        .exc_out(s_exc_out), .data_out(s_data_out), .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
    );

    task automatic chk(input string nm, input string fld, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
        end
    endtask

    function automatic logic [1:0] sat2(input logic [15:0] x);
        return (x > 16'd3) ? 2'd3 : x[1:0];
    endfunction

    // Monitor: every registered output is presented one cycle after its stimulus.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "valid", valid_out, e.v);
            chk(e.name, "instr", instr_out, e.instr);
            chk(e.name, "pc", pc_out, e.pc);
            chk(e.name, "bd", bd_out, e.bd);
            chk(e.name, "exc", exc_out, e.exc);
            chk(e.name, "data", data_out, e.data);
            chk(e.name, "stall_cnt", stall_cnt, e.sc);
            chk(e.name, "bubble_cnt", bubble_cnt, e.bc);
            chk(e.name, "s_valid", s_valid_out, e.v);
            chk(e.name, "s_instr", s_instr_out, e.instr);
            chk(e.name, "s_pc", s_pc_out, e.bub ? 32'h0 : e.pc);
            chk(e.name, "s_bd", s_bd_out, e.bub ? 1'b0 : e.bd);
            chk(e.name, "s_exc", s_exc_out, e.exc);
            chk(e.name, "s_data", s_data_out, e.data);
            chk(e.name, "s_stall_cnt", s_stall_cnt, sat2(e.sc));
            chk(e.name, "s_bubble_cnt", s_bubble_cnt, sat2(e.bc));
        end
    end

    task automatic step(input string nm, input logic v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic bd, input logic [4:0] exc, input logic [95:0] data,
                        input logic [15:0] sc, input logic [15:0] bc, input logic bub);
        exp_t e;
        e.name = nm; e.v = v; e.instr = instr; e.pc = pc; e.bd = bd;
        e.exc = exc; e.data = data; e.sc = sc; e.bc = bc; e.bub = bub;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc, input logic bd,
                         input logic [4:0] ei, input logic [4:0] el, input logic [95:0] d);
        valid_in = v; instr_in = instr; pc_in = pc; bd_in = bd;
        exc_in = ei; exc_local = el; data_in = d;
    endtask

    initial begin
        reset = 1'b1; int_req = 1'b0; flush = 1'b0; stall = 1'b0; clr_cnt = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, '0);
        step("reset", 0, 32'h0, 32'h0, 0, 0, '0, 0, 0, 0);

        reset = 1'b0;
        drive(1, 32'h2408_0005, 32'h3000, 0, 0, 0, D1);
        step("load1", 1, 32'h2408_0005, 32'h3000, 0, 0, D1, 0, 0, 0);
        drive(1, 32'h8C09_0004, 32'h3004, 0, 0, 0, D2);
        step("load2", 1, 32'h8C09_0004, 32'h3004, 0, 0, D2, 0, 0, 0);

        stall = 1'b1;
        drive(1, 32'h1234_5678, 32'h3008, 1, 5'd2, 5'd3, D3);
        for (int i = 1; i <= 3; i++)
            step("stall", 1, 32'h8C09_0004, 32'h3004, 0, 0, D2, 16'(i), 0, 0);

        flush = 1'b1;
        drive(1, 32'h0BAD_0BAD, 32'h300C, 1, 5'd3, 5'd0, D3);
        step("flush_stall", 0, 32'h0, 32'h300C, 1, 0, '0, 3, 1, 1);

        int_req = 1'b1;
        step("int_prio", 0, 32'h0, 32'h0000_4180, 0, 0, '0, 3, 1, 0);

        int_req = 1'b0; flush = 1'b0; stall = 1'b0;
        drive(1, 32'h0100_0010, 32'h3010, 0, 5'd0, 5'd4, D1);
        step("exc_local", 1, 32'h0100_0010, 32'h3010, 0, 5'd4, D1, 3, 1, 0);
        drive(1, 32'h0100_0011, 32'h3014, 0, 5'd10, 5'd4, D2);
        step("exc_first", 1, 32'h0100_0011, 32'h3014, 0, 5'd10, D2, 3, 1, 0);
        drive(0, 32'h0100_0012, 32'h3018, 1, 5'd10, 5'd4, D3);
        step("invalid_bub", 0, 32'h0, 32'h3018, 1, 0, '0, 3, 2, 1);

        clr_cnt = 1'b1;
        drive(1, 32'h2408_0007, 32'h301C, 0, 0, 0, D3);
        step("clr_load", 1, 32'h2408_0007, 32'h301C, 0, 0, D3, 0, 0, 0);
        clr_cnt = 1'b0;

        stall = 1'b1; reset = 1'b1;
        drive(1, 32'h2408_0008, 32'h3020, 1, 5'd1, 0, D1);
        step("reset_stall", 0, 32'h0, 32'h0, 0, 0, '0, 0, 0, 0);
        reset = 1'b0; stall = 1'b0;
        drive(1, 32'h2408_0009, 32'h3020, 0, 0, 0, D1);
        step("post_reset", 1, 32'h2408_0009, 32'h3020, 0, 0, D1, 0, 0, 0);

        stall = 1'b1;
        drive(1, 32'hFFFF_FFFF, 32'h3024, 1, 0, 0, D2);
        for (int i = 1; i <= 5; i++)
            step("sat", 1, 32'h2408_0009, 32'h3020, 0, 0, D1, 16'(i), 0, 0);
        clr_cnt = 1'b1;
        step("clr_stall", 1, 32'h2408_0009, 32'h3020, 0, 0, D1, 0, 0, 0);
        clr_cnt = 1'b0; stall = 1'b0;
        drive(0, 32'h1, 32'h3024, 0, 0, 0, D2);
        step("bub_after", 0, 32'h0, 32'h3024, 0, 0, '0, 0, 1, 1);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
